// File: rtl/stacker_game_ctrl_pkg.sv
// Shared state encodings, default playfield geometry and mask helpers for the
// Stacker game sequencer.
package stacker_game_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MOVE = 3'd1,
        ST_LOCK = 3'd2,
        ST_NEXT = 3'd3,
        ST_LOSE = 3'd4,
        ST_WIN  = 3'd5
    } state_t;

    localparam int DEF_COLS = 7;
    localparam int DEF_ROWS = 12;

    // Index of the lowest set bit; used to slide a trimmed block back to column 0.
    function automatic logic [4:0] lowest_set(input logic [31:0] v);
        logic [4:0] idx;
        idx = '0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) idx = 5'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/stacker_game_ctrl_btn_debounce.sv
// Drop-button conditioning: two-flop synchroniser, stability counter and a
// one-cycle pulse on each accepted rising edge.
module stacker_game_ctrl_btn_debounce #(
    parameter int DEB_CYCLES = 1000000
) (
    input  logic ClkPort,
    input  logic Reset,
    input  logic i_btn,
    output logic o_press
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic          r_sync1;
    logic          r_sync2;
    logic          r_stable;
    logic          r_stable_d;
    logic          r_press;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_stable   <= 1'b0;
            r_stable_d <= 1'b0;
            r_press    <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_sync1    <= i_btn;
            r_sync2    <= r_sync1;
            r_stable_d <= r_stable;
            r_press    <= r_stable & ~r_stable_d;
            // Any bounce back to the accepted level restarts the qualification window.
            if (r_sync2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(DEB_CYCLES - 1)) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/stacker_game_ctrl.sv
// Stacker game sequencer: moving block, locked stack, speed schedule and the
// drop-button driven lock/trim/advance FSM. All logic runs on ClkPort with enables.
module stacker_game_ctrl
    import stacker_game_ctrl_pkg::*;
#(
    parameter int          COLS        = DEF_COLS,
    parameter int          ROWS        = DEF_ROWS,
    parameter int          INIT_WIDTH  = 3,
    parameter logic [31:0] PERIOD0     = 32'd4194304,
    parameter logic [31:0] PERIOD_STEP = 32'd262144,
    parameter logic [31:0] PERIOD_MIN  = 32'd524288,
    parameter int          DEB_CYCLES  = 1000000
) (
    input  logic            ClkPort,
    input  logic            Reset,
    input  logic            btn_drop,
    input  logic [3:0]      rd_row,
    output logic [COLS-1:0] rd_mask,
    output logic [3:0]      level,
    output logic [2:0]      state_o,
    output logic            game_over,
    output logic            game_win,
    output logic [7:0]      score
);

    localparam logic [COLS-1:0] ALL_ONES  = {COLS{1'b1}};
    localparam logic [COLS-1:0] INIT_MASK = ALL_ONES >> (COLS - INIT_WIDTH);

    state_t          r_state;
    logic [3:0]      r_level;
    logic [COLS-1:0] r_moving;
    logic            r_dir;
    logic [31:0]     r_period;
    logic [31:0]     r_tick;
    logic [7:0]      r_score;
    logic            r_over;
    logic            r_win;
    logic [COLS-1:0] r_trimmed;
    logic [COLS-1:0] r_stack [ROWS];

    logic            w_press;
    logic [COLS-1:0] w_below;
    logic [COLS-1:0] w_rd_stack;
    logic [COLS-1:0] w_trimmed;
    logic [COLS-1:0] w_aligned;
    logic [COLS-1:0] w_step_mask;
    logic            w_step_dir;
    logic [31:0]     w_period_next;

    stacker_game_ctrl_btn_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_debounce (
        .ClkPort (ClkPort),
        .Reset   (Reset),
        .i_btn   (btn_drop),
        .o_press (w_press)
    );

    always_comb begin
        w_below    = ALL_ONES;
        w_rd_stack = '0;
        for (int i = 0; i < ROWS; i++) begin
            if (r_level != 4'd0 && 4'(i) == r_level - 4'd1) w_below = r_stack[i];
            if (4'(i) == rd_row) w_rd_stack = r_stack[i];
        end
    end

    assign w_trimmed = r_moving & w_below;
    assign w_aligned = r_trimmed >> lowest_set(32'(r_trimmed));

    // Bounce at either edge so no cell ever leaves the field; a full-width block stays put.
    always_comb begin
        w_step_mask = r_moving;
        w_step_dir  = r_dir;
        if (r_moving != ALL_ONES) begin
            if (r_dir) begin
                if (r_moving[COLS-1]) begin
                    w_step_mask = r_moving >> 1;
                    w_step_dir  = 1'b0;
                end else begin
                    w_step_mask = r_moving << 1;
                end
            end else begin
                if (r_moving[0]) begin
                    w_step_mask = r_moving << 1;
                    w_step_dir  = 1'b1;
                end else begin
                    w_step_mask = r_moving >> 1;
                end
            end
        end
    end

    assign w_period_next = (r_period >= PERIOD_STEP && (r_period - PERIOD_STEP) > PERIOD_MIN)
                         ? (r_period - PERIOD_STEP) : PERIOD_MIN;

    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            r_state   <= ST_IDLE;
            r_level   <= 4'd0;
            r_moving  <= INIT_MASK;
            r_dir     <= 1'b1;
            r_period  <= PERIOD0;
            r_tick    <= 32'd0;
            r_score   <= 8'd0;
            r_over    <= 1'b0;
            r_win     <= 1'b0;
            r_trimmed <= '0;
            for (int i = 0; i < ROWS; i++) r_stack[i] <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_press) begin
                        r_tick  <= 32'd0;
                        r_state <= ST_MOVE;
                    end
                end
                ST_MOVE: begin
                    // A press on a step cycle locks the pre-step position.
                    if (w_press) begin
                        r_state <= ST_LOCK;
                    end else if (r_tick == r_period - 32'd1) begin
                        r_tick   <= 32'd0;
                        r_moving <= w_step_mask;
                        r_dir    <= w_step_dir;
                    end else begin
                        r_tick <= r_tick + 32'd1;
                    end
                end
                ST_LOCK: begin
                    r_trimmed <= w_trimmed;
                    for (int i = 0; i < ROWS; i++) begin
                        if (4'(i) == r_level) r_stack[i] <= w_trimmed;
                    end
                    if (w_trimmed == '0) begin
                        r_over  <= 1'b1;
                        r_state <= ST_LOSE;
                    end else begin
                        if (r_score != 8'hFF) r_score <= r_score + 8'd1;
                        if (r_level == 4'(ROWS - 1)) begin
                            r_win   <= 1'b1;
                            r_state <= ST_WIN;
                        end else begin
                            r_state <= ST_NEXT;
                        end
                    end
                end
                ST_NEXT: begin
                    r_level  <= r_level + 4'd1;
                    r_moving <= w_aligned;
                    r_dir    <= 1'b1;
                    r_period <= w_period_next;
                    r_tick   <= 32'd0;
                    r_state  <= ST_MOVE;
                end
                ST_LOSE, ST_WIN: begin
                    if (w_press) begin
                        r_state   <= ST_IDLE;
                        r_level   <= 4'd0;
                        r_moving  <= INIT_MASK;
                        r_dir     <= 1'b1;
                        r_period  <= PERIOD0;
                        r_tick    <= 32'd0;
                        r_score   <= 8'd0;
                        r_over    <= 1'b0;
                        r_win     <= 1'b0;
                        r_trimmed <= '0;
                        for (int i = 0; i < ROWS; i++) r_stack[i] <= '0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // The moving block overlays its row only while it is still live; once locked the stack shows.
    always_comb begin
        rd_mask = '0;
        if (int'(rd_row) < ROWS && rd_row <= r_level) begin
            if (rd_row == r_level &&
                (r_state == ST_IDLE || r_state == ST_MOVE || r_state == ST_LOCK)) begin
                rd_mask = r_moving;
            end else begin
                rd_mask = w_rd_stack;
            end
        end
    end

    assign level     = r_level;
    assign state_o   = r_state;
    assign game_over = r_over;
    assign game_win  = r_win;
    assign score     = r_score;

endmodule

// File: tb/tb_stacker_game_ctrl.sv
// Scenario bench for stacker_game_ctrl with a small playfield and short timing.
module tb_stacker_game_ctrl;
    import stacker_game_ctrl_pkg::*;

    localparam int ROWS = 4;
    localparam logic [6:0] ALL = 7'h7F;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn = 1'b0;
    logic [3:0] rd_row = 4'd0;
    logic [6:0] rd_mask;
    logic [3:0] level;
    logic [2:0] state_o;
    logic       game_over;
    logic       game_win;
    logic [7:0] score;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [6:0] mask;
        logic [3:0] row;
        logic [2:0] st;
        logic [7:0] score;
    } lock_exp_t;

    lock_exp_t  lock_q[$];
    logic [6:0] mask_q[$];

    logic [6:0] m_stack [ROWS];
    int         m_level;
    int         m_score;
    int         m_period;

    always #5 clk = ~clk;

    stacker_game_ctrl #(
        .COLS(7), .ROWS(4), .INIT_WIDTH(3), .PERIOD0(4),
        .PERIOD_STEP(1), .PERIOD_MIN(2), .DEB_CYCLES(2)
    ) dut (
        .ClkPort   (clk),
        .Reset     (rst),
        .btn_drop  (btn),
        .rd_row    (rd_row),
        .rd_mask   (rd_mask),
        .level     (level),
        .state_o   (state_o),
        .game_over (game_over),
        .game_win  (game_win),
        .score     (score)
    );

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void model_reset();
        for (int i = 0; i < ROWS; i++) m_stack[i] = '0;
        m_level  = 0;
        m_score  = 0;
        m_period = 4;
    endfunction

    function automatic void step_fn(input logic [6:0] m, input bit dr, output logic [6:0] mo, output bit dro);
        mo = m;
        dro = dr;
        if (m != ALL) begin
            if (dr) begin
                if (m[6]) begin mo = m >> 1; dro = 1'b0; end
                else mo = m << 1;
            end else begin
                if (m[0]) begin mo = m << 1; dro = 1'b1; end
                else mo = m >> 1;
            end
        end
    endfunction

    task automatic wait_state(input logic [2:0] st, input int budget, input string nm);
        int k = 0;
        while (state_o !== st && k < budget) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (state_o !== st) begin
            n_err++;
            $display("FAIL %s: state got %0d want %0d", nm, state_o, st);
        end
    endtask

    task automatic press_until(input logic [2:0] st, input string nm);
        @(posedge clk);
        #1 btn = 1'b1;
        @(negedge clk);
        wait_state(st, 20, nm);
        btn = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    // Sync to an observed step, plan the raw edge so the accepted press lands while
    // `target` is showing (or exactly on the step that would leave it), then score it.
    task automatic lock_at(input logic [6:0] target, input bit coincide);
        logic [6:0] prev, cur, m, mn, below, trim, al;
        bit         pv, synced, dr, dn;
        int         k, pe, lo, hi, p;
        lock_exp_t  e;
        prev = '0; cur = '0; pv = 0; synced = 0; k = 0;
        p = m_period;
        rd_row = 4'(m_level);
        while (!synced && k < 200) begin
            @(negedge clk);
            k++;
            cur = rd_mask;
            if (state_o === ST_MOVE) begin
                if (pv && cur !== prev) synced = 1;
                else begin prev = cur; pv = 1; end
            end else begin
                pv = 0;
            end
        end
        n_cmp++;
        if (!synced) begin
            n_err++;
            $display("FAIL lock_sync: no step seen on row %0d", m_level);
            return;
        end
        dr = (cur == (prev << 1));
        m = cur;
        pe = -1;
        for (int j = 0; j < 64 && pe < 0; j++) begin
            lo = j * p + 1;
            hi = (j + 1) * p;
            if (m == target) begin
                if (coincide) begin
                    if (hi >= 7) pe = hi;
                end else if ((lo > 7 ? lo : 7) <= hi) begin
                    pe = (lo > 7) ? lo : 7;
                end
            end
            step_fn(m, dr, mn, dn);
            m = mn;
            dr = dn;
        end
        n_cmp++;
        if (pe < 0) begin
            n_err++;
            $display("FAIL lock_plan: target %b unreachable on row %0d", target, m_level);
            return;
        end
        repeat (pe - 6) @(posedge clk);
        #1 btn = 1'b1;
        below = (m_level == 0) ? ALL : m_stack[m_level - 1];
        trim = target & below;
        e.mask  = trim;
        e.row   = 4'(m_level);
        e.score = (trim != 0) ? 8'(m_score + 1) : 8'(m_score);
        e.st    = (trim == 0) ? ST_LOSE : (m_level == ROWS - 1) ? ST_WIN : ST_NEXT;
        lock_q.push_back(e);
        @(negedge clk);
        wait_state(ST_LOCK, 20, "lock_enter");
        @(negedge clk);
        e = lock_q.pop_front();
        rd_row = e.row;
        #1;
        n_cmp++;
        if (state_o !== e.st) begin n_err++; $display("FAIL lock_state row%0d: got %0d want %0d", e.row, state_o, e.st); end
        n_cmp++;
        if (rd_mask !== e.mask) begin n_err++; $display("FAIL lock_mask row%0d: got %b want %b", e.row, rd_mask, e.mask); end
        n_cmp++;
        if (score !== e.score) begin n_err++; $display("FAIL lock_score row%0d: got %0d want %0d", e.row, score, e.score); end
        n_cmp++;
        if (level !== e.row) begin n_err++; $display("FAIL lock_level: got %0d want %0d", level, e.row); end
        n_cmp++;
        if (game_over !== (e.st == ST_LOSE) || game_win !== (e.st == ST_WIN)) begin
            n_err++;
            $display("FAIL lock_flags row%0d: got over=%b win=%b want over=%b win=%b",
                     e.row, game_over, game_win, e.st == ST_LOSE, e.st == ST_WIN);
        end
        m_stack[m_level] = trim;
        m_score = e.score;
        if (e.st == ST_NEXT) begin
            m_level++;
            m_period = (m_period - 1 > 2) ? m_period - 1 : 2;
            al = trim;
            while (al != 0 && al[0] == 1'b0) al = al >> 1;
            @(negedge clk);
            rd_row = 4'(m_level);
            #1;
            n_cmp++;
            if (state_o !== ST_MOVE || level !== 4'(m_level)) begin
                n_err++;
                $display("FAIL next_row: got state=%0d level=%0d want state=%0d level=%0d",
                         state_o, level, ST_MOVE, m_level);
            end
            n_cmp++;
            if (rd_mask !== al) begin n_err++; $display("FAIL next_mask: got %b want %b", rd_mask, al); end
        end
        btn = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (100) @(negedge clk);
        rd_row = 4'd0;
        #1;
        n_cmp++;
        if (state_o !== ST_IDLE) begin n_err++; $display("FAIL reset_state: got %0d want %0d", state_o, ST_IDLE); end
        n_cmp++;
        if (rd_mask !== 7'b0000111) begin n_err++; $display("FAIL reset_mask0: got %b want 0000111", rd_mask); end
        n_cmp++;
        if (level !== 4'd0 || score !== 8'd0) begin n_err++; $display("FAIL reset_lvl_score: got %0d/%0d want 0/0", level, score); end
        n_cmp++;
        if (game_over !== 1'b0 || game_win !== 1'b0) begin n_err++; $display("FAIL reset_flags: got %b%b want 00", game_over, game_win); end
        rd_row = 4'd1;
        #1;
        n_cmp++;
        if (rd_mask !== 7'b0) begin n_err++; $display("FAIL reset_mask1: got %b want 0000000", rd_mask); end
        rd_row = 4'd9;
        #1;
        n_cmp++;
        if (rd_mask !== 7'b0) begin n_err++; $display("FAIL reset_oob: got %b want 0000000", rd_mask); end
        rd_row = 4'd0;
    endtask

    task automatic test_glitch();
        @(posedge clk);
        #1 btn = 1'b1;
        @(posedge clk);
        #1 btn = 1'b0;
        repeat (20) @(negedge clk);
        n_cmp++;
        if (state_o !== ST_IDLE) begin n_err++; $display("FAIL glitch_state: got %0d want %0d", state_o, ST_IDLE); end
    endtask

    task automatic test_move();
        logic [6:0] prev, want;
        int gap, k;
        rd_row = 4'd0;
        @(posedge clk);
        #1 btn = 1'b1;
        @(negedge clk);
        wait_state(ST_MOVE, 20, "move_start");
        btn = 1'b0;
        mask_q.push_back(7'b0001110);
        mask_q.push_back(7'b0011100);
        mask_q.push_back(7'b0111000);
        mask_q.push_back(7'b1110000);
        mask_q.push_back(7'b0111000);
        prev = rd_mask;
        n_cmp++;
        if (prev !== 7'b0000111) begin n_err++; $display("FAIL move_init: got %b want 0000111", prev); end
        gap = 0;
        k = 0;
        while (mask_q.size() > 0 && k < 40) begin
            @(negedge clk);
            k++;
            gap++;
            if (rd_mask !== prev) begin
                want = mask_q.pop_front();
                n_cmp++;
                if (rd_mask !== want) begin n_err++; $display("FAIL move_step: got %b want %b", rd_mask, want); end
                n_cmp++;
                if (gap != 4) begin n_err++; $display("FAIL move_gap: got %0d cycles want 4", gap); end
                prev = rd_mask;
                gap = 0;
            end
        end
        n_cmp++;
        if (mask_q.size() != 0) begin n_err++; $display("FAIL move_timeout: %0d steps missing", mask_q.size()); end
        mask_q.delete();
    endtask

    task automatic test_async_reset();
        rd_row = 4'd0;
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (state_o !== ST_IDLE) begin n_err++; $display("FAIL async_state: got %0d want %0d", state_o, ST_IDLE); end
        n_cmp++;
        if (rd_mask !== 7'b0000111 || level !== 4'd0 || score !== 8'd0) begin
            n_err++;
            $display("FAIL async_values: got mask=%b level=%0d score=%0d want 0000111/0/0", rd_mask, level, score);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (4) @(negedge clk);
    endtask

    task automatic test_lose();
        press_until(ST_MOVE, "lose_start");
        lock_at(7'b0001110, 1'b0);
        lock_at(7'b0000111, 1'b0);
        lock_at(7'b0110000, 1'b0);
        repeat (20) @(negedge clk);
        rd_row = 4'd0;
        #1;
        n_cmp++;
        if (rd_mask !== 7'b0001110) begin n_err++; $display("FAIL lose_row0: got %b want 0001110", rd_mask); end
        rd_row = 4'd1;
        #1;
        n_cmp++;
        if (rd_mask !== 7'b0000110) begin n_err++; $display("FAIL lose_row1: got %b want 0000110", rd_mask); end
        rd_row = 4'd2;
        #1;
        n_cmp++;
        if (rd_mask !== 7'b0 || state_o !== ST_LOSE) begin
            n_err++;
            $display("FAIL lose_frozen: got row2=%b state=%0d want 0000000/%0d", rd_mask, state_o, ST_LOSE);
        end
        press_until(ST_IDLE, "lose_restart");
        model_reset();
        rd_row = 4'd0;
        #1;
        n_cmp++;
        if (rd_mask !== 7'b0000111 || score !== 8'd0 || game_over !== 1'b0 || level !== 4'd0) begin
            n_err++;
            $display("FAIL lose_cleared: got mask=%b score=%0d over=%b level=%0d want 0000111/0/0/0",
                     rd_mask, score, game_over, level);
        end
        rd_row = 4'd1;
        #1;
        n_cmp++;
        if (rd_mask !== 7'b0) begin n_err++; $display("FAIL lose_row1_cleared: got %b want 0000000", rd_mask); end
    endtask

    task automatic test_win();
        press_until(ST_MOVE, "win_start");
        for (int r = 0; r < ROWS; r++) lock_at(7'b0000111, 1'b0);
        n_cmp++;
        if (score !== 8'd4 || game_win !== 1'b1 || level !== 4'd3) begin
            n_err++;
            $display("FAIL win_final: got score=%0d win=%b level=%0d want 4/1/3", score, game_win, level);
        end
        press_until(ST_IDLE, "win_restart");
        model_reset();
        n_cmp++;
        if (game_win !== 1'b0 || score !== 8'd0) begin
            n_err++;
            $display("FAIL win_cleared: got win=%b score=%0d want 0/0", game_win, score);
        end
    endtask

    task automatic test_coincident();
        press_until(ST_MOVE, "coin_start");
        lock_at(7'b0011100, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (4) @(negedge clk);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_glitch();
        test_move();
        test_async_reset();
        test_lose();
        test_win();
        test_coincident();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
